// File: rtl/popcount_accumulator_if.sv
// popcount_accumulator_if: word input and frame-result output handshakes for popcount_accumulator
interface popcount_accumulator_if #(
    parameter int POS_W = 4,
    parameter int ACC_W = 8,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [POS_W-1:0] in_count;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_total;
    logic [CNT_W-1:0] out_words;
    logic             out_overflow;

    modport master (
        output in_valid, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_total, out_words, out_overflow
    );

    modport slave (
        input  in_valid, in_count, in_last, out_ready,
        output in_ready, out_valid, out_total, out_words, out_overflow
    );
endinterface

// File: rtl/popcount_accumulator.sv
// popcount_accumulator: sums per-word ones-counts over a frame; POPCOUNT_ACC_SATURATE_EN clamps instead of wrapping
module popcount_accumulator #(
    parameter int DATA_W    = 10,
    parameter int POS_W     = $clog2(DATA_W) + int'($clog2(DATA_W) != $clog2(DATA_W)),
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input logic                  clk,
    input logic                  rst,
    popcount_accumulator_if.slave bus
);
    typedef enum logic {ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [ACC_W-1:0] acc_q, acc_d, total_q, total_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, words_q, words_d;
    logic             ovf_q, ovf_d, oflow_q, oflow_d;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next, accept, close;

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = state_q == DONE;
    assign bus.out_total    = total_q;
    assign bus.out_words    = words_q;
    assign bus.out_overflow = oflow_q;

    // Widened add so the carry out marks overflow; the flag is sticky for the frame
    always_comb begin
        sum      = {1'b0, acc_q} + {{(ACC_W + 1 - POS_W){1'b0}}, bus.in_count};
        ovf_next = ovf_q | sum[ACC_W];
`ifdef POPCOUNT_ACC_SATURATE_EN
        acc_next = ovf_next ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
    end

    // Frame FSM: accumulate words, latch the result on close, hold it until taken
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        total_d = total_q;
        words_d = words_q;
        oflow_d = oflow_q;
        accept  = in_ready_q && bus.in_valid;
        close   = accept && (bus.in_last || cnt_q == CNT_W'(FRAME_LEN - 1));
        if (state_q == ACCUM) begin
            if (accept) begin
                acc_d = acc_next;
                cnt_d = cnt_q + CNT_W'(1);
                ovf_d = ovf_next;
            end
            if (close) begin
                state_d = DONE;
                total_d = acc_next;
                words_d = cnt_q + CNT_W'(1);
                oflow_d = ovf_next;
            end
        end else if (bus.out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
        in_ready_d = state_d == ACCUM;
    end

    // State registers with synchronous reset discarding any partial frame or pending result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            in_ready_q <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            total_q    <= '0;
            words_q    <= '0;
            oflow_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            total_q    <= total_d;
            words_q    <= words_d;
            oflow_q    <= oflow_d;
        end
    end
endmodule

// File: tb/tb_popcount_accumulator.sv
// tb_popcount_accumulator: drives an 8-bit and a 6-bit accumulator in lockstep and scoreboards frame results
module tb_popcount_accumulator;
    typedef struct {
        int sum;
        int words;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total_n = 0;
    int   bad_n = 0;
    int   m_sum = 0;
    int   m_cnt = 0;
    res_t sb[$];
    res_t e;
    int   e8, e6;
    logic o8, o6;

    popcount_accumulator_if #(.POS_W(4), .ACC_W(8), .CNT_W(5)) b0 ();
    popcount_accumulator_if #(.POS_W(4), .ACC_W(6), .CNT_W(5)) b1 ();

    popcount_accumulator #(.DATA_W(10), .FRAME_LEN(16), .ACC_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
    popcount_accumulator #(.DATA_W(10), .FRAME_LEN(16), .ACC_W(6)) u1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Scoreboard: pop and compare both widths whenever a result handshake is about to happen
    always @(negedge clk) begin
        if (b0.out_valid === 1'b1 && b0.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total_n++; bad_n++;
                $display("FAIL unexpected_result total=%0d words=%0d required=none", b0.out_total, b0.out_words);
            end else begin
                e  = sb.pop_front();
                o8 = e.sum > 255;
                o6 = e.sum > 63;
`ifdef POPCOUNT_ACC_SATURATE_EN
                e8 = o8 ? 255 : e.sum;
                e6 = o6 ? 63 : e.sum;
`else
                e8 = e.sum % 256;
                e6 = e.sum % 64;
`endif
                total_n += 7;
                if (b0.out_total !== e8[7:0]) begin bad_n++; $display("FAIL total8 got=%0d exp=%0d", b0.out_total, e8); end
                if (b1.out_total !== e6[5:0]) begin bad_n++; $display("FAIL total6 got=%0d exp=%0d", b1.out_total, e6); end
                if (b0.out_words !== e.words[4:0]) begin bad_n++; $display("FAIL words8 got=%0d exp=%0d", b0.out_words, e.words); end
                if (b1.out_words !== e.words[4:0]) begin bad_n++; $display("FAIL words6 got=%0d exp=%0d", b1.out_words, e.words); end
                if (b0.out_overflow !== o8) begin bad_n++; $display("FAIL ovf8 got=%b exp=%b", b0.out_overflow, o8); end
                if (b1.out_overflow !== o6) begin bad_n++; $display("FAIL ovf6 got=%b exp=%b", b1.out_overflow, o6); end
                if (b1.out_valid !== 1'b1) begin bad_n++; $display("FAIL valid6 got=%b exp=1", b1.out_valid); end
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] c, input logic l);
        b0.in_valid = v; b0.in_count = c; b0.in_last = l;
        b1.in_valid = v; b1.in_count = c; b1.in_last = l;
    endtask

    task automatic set_ready(input logic r);
        b0.out_ready = r;
        b1.out_ready = r;
    endtask

    task automatic send(input logic [3:0] c, input logic l);
        int n = 0;
        drive(1'b1, c, l);
        @(negedge clk);
        while (b0.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (b0.in_ready !== 1'b1) begin
            total_n++; bad_n++;
            $display("FAIL send_timeout in_ready=%b required=1", b0.in_ready);
        end else begin
            m_sum += int'(c);
            m_cnt++;
            if (l || m_cnt == 16) begin
                sb.push_back('{m_sum, m_cnt});
                m_sum = 0;
                m_cnt = 0;
            end
        end
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(posedge clk); #1;
            total_n += 5;
            if (b0.in_ready !== 1'b0) begin bad_n++; $display("FAIL rst_in_ready got=%b exp=0", b0.in_ready); end
            if (b0.out_valid !== 1'b0) begin bad_n++; $display("FAIL rst_out_valid got=%b exp=0", b0.out_valid); end
            if (b0.out_total !== 8'd0) begin bad_n++; $display("FAIL rst_total got=%0d exp=0", b0.out_total); end
            if (b0.out_words !== 5'd0) begin bad_n++; $display("FAIL rst_words got=%0d exp=0", b0.out_words); end
            if (b1.out_overflow !== 1'b0) begin bad_n++; $display("FAIL rst_ovf got=%b exp=0", b1.out_overflow); end
        end
        rst = 1'b0;
        @(negedge clk);
        total_n++;
        if (b0.in_ready !== 1'b0) begin bad_n++; $display("FAIL rst_release_early got=%b exp=0", b0.in_ready); end
        @(posedge clk); #1;
        total_n++;
        if (b0.in_ready !== 1'b1) begin bad_n++; $display("FAIL rst_release got=%b exp=1", b0.in_ready); end
    endtask

    task automatic test_basic();
        set_ready(1'b1);
        send(4'd3, 1'b0);
        send(4'd5, 1'b0);
        send(4'd2, 1'b1);
        @(negedge clk);
        total_n += 3;
        if (b0.out_valid !== 1'b1) begin bad_n++; $display("FAIL basic_latency got=%b exp=1", b0.out_valid); end
        if (b0.in_ready !== 1'b0) begin bad_n++; $display("FAIL basic_in_ready got=%b exp=0", b0.in_ready); end
        if (b0.out_total !== 8'd10) begin bad_n++; $display("FAIL basic_total got=%0d exp=10", b0.out_total); end
        @(negedge clk);
        total_n += 2;
        if (b0.out_valid !== 1'b0) begin bad_n++; $display("FAIL basic_one_cycle got=%b exp=0", b0.out_valid); end
        if (b0.in_ready !== 1'b1) begin bad_n++; $display("FAIL basic_bubble got=%b exp=1", b0.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        send(4'd6, 1'b0);
        send(4'd9, 1'b0);
        rst = 1'b1;
        m_sum = 0;
        m_cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            total_n += 4;
            if (b0.in_ready !== 1'b0) begin bad_n++; $display("FAIL mid_in_ready got=%b exp=0", b0.in_ready); end
            if (b0.out_valid !== 1'b0) begin bad_n++; $display("FAIL mid_out_valid got=%b exp=0", b0.out_valid); end
            if (b0.out_total !== 8'd0) begin bad_n++; $display("FAIL mid_total got=%0d exp=0", b0.out_total); end
            if (b0.out_words !== 5'd0) begin bad_n++; $display("FAIL mid_words got=%0d exp=0", b0.out_words); end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        send(4'd1, 1'b0);
        send(4'd6, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_autoclose();
        for (int i = 0; i < 16; i++) send(4'd7, 1'b0);
        @(negedge clk);
        total_n += 2;
        if (b0.out_total !== 8'd112) begin bad_n++; $display("FAIL auto_total got=%0d exp=112", b0.out_total); end
        if (b0.out_words !== 5'd16) begin bad_n++; $display("FAIL auto_words got=%0d exp=16", b0.out_words); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) send(4'd10, i == 9);
        @(negedge clk);
        total_n += 2;
`ifdef POPCOUNT_ACC_SATURATE_EN
        if (b1.out_total !== 6'd63) begin bad_n++; $display("FAIL ovf_total6 got=%0d exp=63", b1.out_total); end
`else
        if (b1.out_total !== 6'd36) begin bad_n++; $display("FAIL ovf_total6 got=%0d exp=36", b1.out_total); end
`endif
        if (b1.out_overflow !== 1'b1) begin bad_n++; $display("FAIL ovf_flag6 got=%b exp=1", b1.out_overflow); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        set_ready(1'b0);
        send(4'd2, 1'b0);
        send(4'd9, 1'b1);
        drive(1'b1, 4'd4, 1'b1);
        repeat (5) begin
            @(negedge clk);
            total_n += 4;
            if (b0.in_ready !== 1'b0) begin bad_n++; $display("FAIL stall_in_ready got=%b exp=0", b0.in_ready); end
            if (b0.out_valid !== 1'b1) begin bad_n++; $display("FAIL stall_valid got=%b exp=1", b0.out_valid); end
            if (b0.out_total !== 8'd11) begin bad_n++; $display("FAIL stall_total got=%0d exp=11", b0.out_total); end
            if (b0.out_words !== 5'd2) begin bad_n++; $display("FAIL stall_words got=%0d exp=2", b0.out_words); end
        end
        @(posedge clk); #1;
        set_ready(1'b1);
        @(negedge clk);
        total_n++;
        if (b0.in_ready !== 1'b0) begin bad_n++; $display("FAIL release_in_ready got=%b exp=0", b0.in_ready); end
        @(negedge clk);
        total_n += 2;
        if (b0.in_ready !== 1'b1) begin bad_n++; $display("FAIL release_accept got=%b exp=1", b0.in_ready); end
        if (b0.out_valid !== 1'b0) begin bad_n++; $display("FAIL release_valid got=%b exp=0", b0.out_valid); end
        sb.push_back('{4, 1});
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 1'b0);
        @(negedge clk);
        total_n += 2;
        if (b0.out_valid !== 1'b1) begin bad_n++; $display("FAIL next_frame_valid got=%b exp=1", b0.out_valid); end
        if (b0.out_total !== 8'd4) begin bad_n++; $display("FAIL next_frame_total got=%0d exp=4", b0.out_total); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        send(4'd0, 1'b1);
        @(negedge clk);
        total_n += 2;
        if (b0.out_total !== 8'd0) begin bad_n++; $display("FAIL single_total got=%0d exp=0", b0.out_total); end
        if (b0.out_words !== 5'd1) begin bad_n++; $display("FAIL single_words got=%0d exp=1", b0.out_words); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 6; f++) begin
            int len = int'($urandom_range(1, 20));
            for (int w = 0; w < len; w++) send(4'($urandom_range(0, 15)), w == len - 1);
        end
    endtask

    initial begin
        drive(1'b0, 4'd0, 1'b0);
        set_ready(1'b0);
        test_reset();
        test_basic();
        test_reset_midframe();
        test_autoclose();
        test_overflow();
        test_stall();
        test_single();
        test_back_to_back();
        repeat (4) @(posedge clk);
        #1;
        total_n++;
        if (sb.size() != 0) begin bad_n++; $display("FAIL sb_drain left=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule
